// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register word offsets, STATUS bit positions and the TX FSM state encoding.
package mmio_uart_pkg;

    // Register word offsets (req_addr[3:2]).
    localparam logic [1:0] OFF_TXDATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV  = 2'd2;
    localparam logic [1:0] OFF_UNMAPPED = 2'd3;

    // STATUS register bit positions.
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser.
// First-word-fall-through: rdata always shows the oldest entry.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    // Storage array: written on push only.
    // NOTE: the data array has no reset; occupancy is tracked by cnt, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, TXDATA/STATUS/BAUDDIV registers,
// byte FIFO and 8N1 serialiser FSM.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 16,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tx,
    output logic        tx_busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       offset;
    logic             txdata_wr;
    logic             accept;
    logic [31:0]      rd_data;
    logic             rd_err;
    logic [DIV_W-1:0] baud_div;
    logic [DIV_W-1:0] eff_div;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_rdata;
    logic             fifo_has_data;

    tx_state_e        state, state_d;
    logic             load;
    logic             bit_done;
    logic             tx_bit;
    logic [7:0]       shifter;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_lat;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic             unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_wdata};

    assign offset    = req_addr[3:2];
    assign txdata_wr = req_valid & req_we & (offset == OFF_TXDATA);
    assign req_ready = !(txdata_wr & fifo_full);
    assign accept    = req_valid & req_ready;

    assign fifo_has_data = (fifo_count != '0);
    assign tx_busy       = (state != IDLE) | !fifo_empty;
    assign eff_div       = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign bit_done      = (baud_cnt == '0);
    assign tx            = tx_bit;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept & txdata_wr),
        .pop   (load),
        .wdata (req_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read-data and error decode for the request currently on the bus.
    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (offset)
            OFF_TXDATA: ;
            OFF_STATUS: begin
                if (!req_we) begin
                    rd_data[ST_FULL]  = fifo_full;
                    rd_data[ST_EMPTY] = fifo_empty;
                    rd_data[ST_BUSY]  = tx_busy;
                end
            end
            OFF_BAUDDIV: begin
                if (!req_we) rd_data = 32'(baud_div);
            end
            default: rd_err = 1'b1;
        endcase
    end

    // Registered response, exactly one cycle after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_rdata <= accept ? rd_data : '0;
            rsp_err   <= accept & rd_err;
        end
    end

    // BAUDDIV register; the serialiser only samples it when a frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div <= DIV_W'(DEFAULT_DIV);
        end else if (accept && req_we && offset == OFF_BAUDDIV) begin
            baud_div <= req_wdata[DIV_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next state, FIFO pop/load strobe and serial output level.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        tx_bit  = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_has_data) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                tx_bit = shifter[0];
                if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_bit = parity_bit;
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (fifo_has_data) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter, bit counter and baud counter; divider latched at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shifter  <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_lat  <= DIV_W'(1);
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (load) begin
            shifter  <= fifo_rdata;
            bit_cnt  <= '0;
            div_lat  <= eff_div;
            baud_cnt <= eff_div - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_rdata;
`endif
        end else if (state != IDLE) begin
            if (bit_done) begin
                baud_cnt <= div_lat - DIV_W'(1);
                if (state == DATA) begin
                    shifter <= {1'b0, shifter[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tx;
    logic        tx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int stalls [10];

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    mmio_uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus transfer, then check the response on the following cycle.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) check({tag, " ready timeout"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // Back-to-back TXDATA writes with valid held high; records stall cycles per write.
    task automatic stream_writes(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 4'h0;
            req_wdata = 32'(base + 8'(k));
            stalls[k] = 0;
            while (!req_ready && stalls[k] < 1000) begin
                stalls[k]++;
                @(negedge clk);
            end
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Watch tx for one frame; each bit must hold its level for div samples.
    task automatic expect_frame(input logic [7:0] d, input int div, input bit b2b, input string tag);
        logic [10:0] bits;
        int waited = 0;
        logic ok;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b0, 1'b1, d, 1'b0};
`endif
        @(negedge clk);
        if (!b2b) begin
            while (tx !== 1'b0 && waited < 500) begin
                @(negedge clk);
                waited++;
            end
        end
        check({tag, " start seen"}, 32'(tx), 32'd0);
        for (int i = 0; i < FRAME_BITS; i++) begin
            ok = 1'b1;
            for (int c = 0; c < div; c++) begin
                if (i > 0 || c > 0) @(negedge clk);
                if (tx !== bits[i]) ok = 1'b0;
            end
            check($sformatf("%s bit%0d", tag, i), 32'(ok), 32'd1);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " idle tx"}, 32'(tx), 32'd1);
        check({tag, " idle busy"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        rst = 1'b1;

        // BAUDDIV reset value and empty STATUS.
        bus_xfer(1'b0, 4'h8, 32'h0, 32'd16, 1'b0, "baud reset");
        bus_xfer(1'b0, 4'h4, 32'h0, 32'h2, 1'b0, "status reset");

        // Reset in the middle of a frame with a byte still queued.
        bus_xfer(1'b1, 4'h0, 32'hA3, 32'h0, 1'b0, "wr A3");
        bus_xfer(1'b1, 4'h0, 32'h11, 32'h0, 1'b0, "wr 11");
        repeat (30) @(negedge clk);
        check("midframe busy", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst tx_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_xfer(1'b0, 4'h4, 32'h0, 32'h2, 1'b0, "status after rst");

        // DIV=0 behaves as one clock per bit.
        bus_xfer(1'b1, 4'h8, 32'h0, 32'h0, 1'b0, "wr div0");
        bus_xfer(1'b0, 4'h8, 32'h0, 32'h0, 1'b0, "rd div0");
        bus_xfer(1'b1, 4'h0, 32'h3C, 32'h0, 1'b0, "wr 3C");
        expect_frame(8'h3C, 1, 1'b0, "div0 3C");
        idle_check("div0");

        // Basic frame at DIV=4.
        bus_xfer(1'b1, 4'h8, 32'h4, 32'h0, 1'b0, "wr div4");
        bus_xfer(1'b1, 4'h0, 32'h55, 32'h0, 1'b0, "wr 55");
        expect_frame(8'h55, 4, 1'b0, "div4 55");
        idle_check("div4");

        // Unmapped offset: error response, no side effects.
        bus_xfer(1'b1, 4'hC, 32'h99, 32'h0, 1'b1, "wr 0xC");
        bus_xfer(1'b0, 4'hC, 32'h0, 32'h0, 1'b1, "rd 0xC");
        bus_xfer(1'b0, 4'h8, 32'h0, 32'd4, 1'b0, "baud after 0xC");
        bus_xfer(1'b0, 4'h4, 32'h0, 32'h2, 1'b0, "status after 0xC");

        // FIFO fill with back-to-back frames at DIV=2.
        bus_xfer(1'b1, 4'h8, 32'h2, 32'h0, 1'b0, "wr div2");
        fork
            stream_writes(10, 8'h10);
            begin
                expect_frame(8'h10, 2, 1'b0, "b2b f0");
                for (int k = 1; k < 10; k++)
                    expect_frame(8'h10 + 8'(k), 2, 1'b1, $sformatf("b2b f%0d", k));
            end
        join
        for (int k = 0; k < 9; k++)
            check($sformatf("stall w%0d", k), 32'(stalls[k]), 32'd0);
        check("stall w9", 32'(stalls[9]), 32'(2 * FRAME_BITS - 7));
        idle_check("b2b");

        // BAUDDIV change mid-frame applies to the next frame only.
        bus_xfer(1'b1, 4'h8, 32'h4, 32'h0, 1'b0, "wr div4 again");
        fork
            begin
                bus_xfer(1'b1, 4'h0, 32'h0F, 32'h0, 1'b0, "wr 0F");
                bus_xfer(1'b1, 4'h0, 32'hF0, 32'h0, 1'b0, "wr F0");
                repeat (10) @(negedge clk);
                bus_xfer(1'b1, 4'h8, 32'h8, 32'h0, 1'b0, "wr div8");
            end
            begin
                expect_frame(8'h0F, 4, 1'b0, "chg f0");
                expect_frame(8'hF0, 8, 1'b1, "chg f1");
            end
        join
        idle_check("chg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
